writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: result/data width.
REQ-002 SHALL have parameter ADDR_W, default 5: destination register index width.
REQ-003 SHALL have parameter LQ_DEPTH, default 4: load-result queue entries, power of two, at least 2.
REQ-004 SHALL have parameter STARVE_MAX, default 8: consecutive cycles a non-empty queue may be blocked before it is forced.
REQ-005 SHALL have port clk, in, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, in, 1: reset, synchronous, active-low.
REQ-007 SHALL have ports alu_valid (in, 1), alu_rd (in, ADDR_W) and alu_data (in, DATA_W): ALU result; has no ready signal.
REQ-008 SHALL have ports ld_valid (in, 1), ld_ready (out, 1), ld_rd (in, ADDR_W) and ld_data (in, DATA_W): load result, valid/ready handshake.
REQ-009 SHALL have port alu_stall, out, 1: upstream must hold alu_valid low while it is 1.
REQ-010 SHALL have ports RegWrite (out, 1), WriteReg (out, ADDR_W) and WriteData (out, DATA_W): registered register-file write port.
REQ-011 SHALL have ports rs1, rs2 (in, ADDR_W), rf_data1, rf_data2 (in, DATA_W) and fwd_data1, fwd_data2 (out, DATA_W): operand forwarding.
REQ-012 SHALL have port err_drop, out, 1: sticky flag set when an ALU result was lost.

Function
REQ-013 SHALL accept a load beat only on a rising edge with ld_valid=1 and ld_ready=1; the beat is pushed to the queue tail.
REQ-014 SHALL drive ld_ready=1 exactly when queue count < LQ_DEPTH, independent of a same-cycle pop; a full queue takes no push even while popping.
REQ-015 SHALL treat alu_valid=1 with alu_rd=0 as no request.
REQ-016 SHALL select one source per cycle: the queue head when alu_stall=1 and the queue is non-empty; else the ALU when it is a request; else the queue head when the queue is non-empty; else nothing.
REQ-017 SHALL register the selected write on the next edge: RegWrite=1 and WriteReg/WriteData = source rd/data; RegWrite=0 when nothing is selected.
REQ-018 SHALL pop a selected queue head even when its rd=0, but then drive RegWrite=0 (write to r0 is discarded).
REQ-019 SHALL have latency: ALU result to RegWrite=1 is 1 cycle; load acceptance to RegWrite=1 is at least 2 cycles.
REQ-020 SHALL keep a starvation counter: increment when the queue is non-empty and not popped; clear on any pop or when empty; saturate at STARVE_MAX.
REQ-021 SHALL drive alu_stall=1 combinationally when counter = STARVE_MAX and the queue is non-empty.
REQ-022 SHALL set err_drop on an edge where alu_stall=1 and an ALU request is present; err_drop clears only on reset.
REQ-023 SHALL wrap queue pointers modulo LQ_DEPTH and preserve FIFO order across wrap.
REQ-024 SHALL hold WriteReg/WriteData at their last values while RegWrite=0.

Reset
REQ-025 SHALL, on a rising edge with rst_n=0, empty the queue, clear the counter and err_drop, and set RegWrite=0 and WriteReg/WriteData to 0.
REQ-026 SHALL drive ld_ready=0 and alu_stall=0 while rst_n=0.
REQ-027 SHALL discard in-flight queue contents on reset mid-operation; no write from them appears after reset.

Configuration
REQ-028 SHALL, with macro WB_BYPASS_EN defined, drive fwd_data1 = WriteData when RegWrite=1, WriteReg=rs1 and rs1!=0; else fwd_data1 = rf_data1. fwd_data2 uses rs2/rf_data2 the same way.
REQ-029 SHALL, without WB_BYPASS_EN, keep all forwarding ports and drive fwd_data1=rf_data1 and fwd_data2=rf_data2.

Verification
REQ-030 SHALL cover: alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF for one cycle -> next cycle RegWrite=1, WriteReg=3, WriteData=0xDEADBEEF, then RegWrite=0.
REQ-031 SHALL cover: loads rd=1..5 offered back-to-back with no ALU traffic -> ld_ready=0 only while 4 are held, and writes retire in order 1,2,3,4,5.
REQ-032 SHALL cover: queue holds rd=7 while ALU requests for 8 consecutive cycles -> alu_stall=1 in the 9th cycle, rd=7 is written next, and err_drop=1 if ALU stays valid during the stall.
REQ-033 SHALL cover: load rd=0, data 0x55 -> entry popped, RegWrite never asserted, ld_ready=1 again afterward.
REQ-034 SHALL cover, with WB_BYPASS_EN: RegWrite=1, WriteReg=4, WriteData=0x10, rs1=4, rf_data1=0x99 -> fwd_data1=0x10; rs1=0 -> fwd_data1=rf_data1.
REQ-035 SHALL cover: rst_n=0 for one edge with 3 entries queued -> next cycle RegWrite=0, ld_ready=1 and no stale writes occur.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates an ALU result against a queued load result onto one registered RF write port.
// Optional macro WB_BYPASS_EN enables forwarding of the registered write to the operand read ports.
module writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int LQ_DEPTH   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              alu_stall,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic              err_drop
);

    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {SEL_NONE, SEL_ALU, SEL_LQ} sel_e;

    logic [ADDR_W-1:0] q_rd   [LQ_DEPTH];
    logic [DATA_W-1:0] q_data [LQ_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve;

    logic              q_empty, q_full, alu_req, push, pop;
    sel_e              sel;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    assign q_empty   = (count == '0);
    assign q_full    = (count == CNT_W'(LQ_DEPTH));
    assign alu_req   = alu_valid && (alu_rd != '0);
    assign ld_ready  = rst_n && !q_full;
    assign alu_stall = rst_n && !q_empty && (starve == STV_W'(STARVE_MAX));
    assign push      = ld_valid && ld_ready;
    assign pop       = (sel == SEL_LQ);

    // A starved queue preempts the ALU; otherwise the ALU has priority.
    always_comb begin
        sel      = SEL_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (alu_stall) begin
            sel      = SEL_LQ;
            sel_rd   = q_rd[head];
            sel_data = q_data[head];
        end else if (alu_req) begin
            sel      = SEL_ALU;
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (!q_empty) begin
            sel      = SEL_LQ;
            sel_rd   = q_rd[head];
            sel_data = q_data[head];
        end
    end

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail]   <= ld_rd;
            q_data[tail] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            starve    <= '0;
            err_drop  <= 1'b0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (q_empty || pop)
                starve <= '0;
            else if (starve != STV_W'(STARVE_MAX))
                starve <= starve + STV_W'(1);

            if (alu_stall && alu_req) err_drop <= 1'b1;

            // Writes to r0 are swallowed; the last real write stays visible.
            RegWrite <= (sel != SEL_NONE) && (sel_rd != '0);
            if ((sel != SEL_NONE) && (sel_rd != '0)) begin
                WriteReg  <= sel_rd;
                WriteData <= sel_data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd_data1 = (RegWrite && (WriteReg == rs1) && (rs1 != '0)) ? WriteData : rf_data1;
    assign fwd_data2 = (RegWrite && (WriteReg == rs2) && (rs2 != '0)) ? WriteData : rf_data2;
`else
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};
    assign fwd_data1 = rf_data1;
    assign fwd_data2 = rf_data2;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, hand sequences and a random run against a queue model.
module tb_writeback_stage;
    localparam int DW = 32, AW = 5, DEPTH = 4, SMAX = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, ld_valid, ld_ready, alu_stall, RegWrite, err_drop;
    logic [AW-1:0] alu_rd, ld_rd, WriteReg, rs1, rs2;
    logic [DW-1:0] alu_data, ld_data, WriteData, rf_data1, rf_data2, fwd_data1, fwd_data2;

    always #5 clk = ~clk;

    writeback_stage #(.DATA_W(DW), .ADDR_W(AW), .LQ_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .alu_stall(alu_stall),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .rs1(rs1), .rs2(rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .err_drop(err_drop)
    );

    typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } ent_t;

    // Reference model: a plain queue plus the observable registered outputs.
    ent_t          mq[$];
    int            m_starve;
    logic          m_err, m_rw;
    logic [AW-1:0] m_wr;
    logic [DW-1:0] m_wd;

    logic cur_ready, cur_stall;
    int   checks = 0, failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        rst_n = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        rs1 = '0; rs2 = '0; rf_data1 = '0; rf_data2 = '0;
    endtask

    // One clock: check combinational outputs, take the edge, advance the model, check registers.
    task automatic tick();
        logic          e_ready, e_stall, areq, popped;
        logic [DW-1:0] e1, e2;
        int            n;
        ent_t          h;
        #1;
        n       = mq.size();
        e_ready = rst_n && (n < DEPTH);
        e_stall = rst_n && (n > 0) && (m_starve == SMAX);
        e1 = rf_data1;
        e2 = rf_data2;
`ifdef WB_BYPASS_EN
        if (m_rw && m_wr == rs1 && rs1 != '0) e1 = m_wd;
        if (m_rw && m_wr == rs2 && rs2 != '0) e2 = m_wd;
`endif
        chk("ld_ready", 32'(ld_ready), 32'(e_ready));
        chk("alu_stall", 32'(alu_stall), 32'(e_stall));
        chk("fwd_data1", fwd_data1, e1);
        chk("fwd_data2", fwd_data2, e2);
        cur_ready = ld_ready;
        cur_stall = alu_stall;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete(); m_starve = 0; m_err = 1'b0; m_rw = 1'b0; m_wr = '0; m_wd = '0;
        end else begin
            areq   = alu_valid && (alu_rd != '0);
            popped = 1'b0;
            m_rw   = 1'b0;
            if (n > 0 && (e_stall || !areq)) begin
                h = mq.pop_front();
                popped = 1'b1;
                if (h.rd != '0) begin m_rw = 1'b1; m_wr = h.rd; m_wd = h.data; end
            end else if (areq) begin
                m_rw = 1'b1; m_wr = alu_rd; m_wd = alu_data;
            end
            if (e_stall && areq) m_err = 1'b1;
            if (ld_valid && n < DEPTH) mq.push_back('{ld_rd, ld_data});
            if (n == 0 || popped) m_starve = 0;
            else if (m_starve < SMAX) m_starve++;
        end
        #1;
        chk("RegWrite", 32'(RegWrite), 32'(m_rw));
        chk("WriteReg", 32'(WriteReg), 32'(m_wr));
        chk("WriteData", WriteData, m_wd);
        chk("err_drop", 32'(err_drop), 32'(m_err));
    endtask

    typedef struct {
        logic av; logic [AW-1:0] ard; logic [DW-1:0] ad;
        logic lv; logic [AW-1:0] lrd; logic [DW-1:0] ldat;
        logic e_ready; logic e_rw; logic [AW-1:0] e_wr; logic [DW-1:0] e_wd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int low;
        // ALU single write, then loads rd=1..5 back-to-back, then a load to r0.
        tbl[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 5'd3, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 5'd3, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 32'h101, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 32'h102, 1'b1, 1'b1, 5'd1, 32'h101};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h103, 1'b1, 1'b1, 5'd2, 32'h102};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h104, 1'b1, 1'b1, 5'd3, 32'h103};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h105, 1'b1, 1'b1, 5'd4, 32'h104};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 5'd5, 32'h105};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 5'd5, 32'h105};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55,  1'b1, 1'b0, 5'd5, 32'h105};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 5'd5, 32'h105};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 5'd5, 32'h105};

        mq.delete(); m_starve = 0; m_err = 1'b0; m_rw = 1'b0; m_wr = '0; m_wd = '0;
        set_idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_ld_ready_low", 32'(cur_ready), 32'(1'b0));
        chk("rst_RegWrite", 32'(RegWrite), 32'(1'b0));
        chk("rst_WriteData", WriteData, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            set_idle();
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
            ld_valid = tbl[i].lv; ld_rd = tbl[i].lrd; ld_data = tbl[i].ldat;
            tick();
            chk($sformatf("vec%0d_ld_ready", i), 32'(cur_ready), 32'(tbl[i].e_ready));
            chk($sformatf("vec%0d_RegWrite", i), 32'(RegWrite), 32'(tbl[i].e_rw));
            chk($sformatf("vec%0d_WriteReg", i), 32'(WriteReg), 32'(tbl[i].e_wr));
            chk($sformatf("vec%0d_WriteData", i), WriteData, tbl[i].e_wd);
        end

        // Starvation: rd=7 waits behind 8 ALU cycles, is forced in the 9th, ALU drop flagged.
        set_idle();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h900;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        tick();
        ld_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            alu_data = 32'(i);
            tick();
            chk("starve_no_stall", 32'(cur_stall), 32'(1'b0));
            chk("starve_alu_wins", 32'(WriteReg), 32'd9);
        end
        tick();
        chk("starve_stall", 32'(cur_stall), 32'(1'b1));
        chk("starve_forced_rd", 32'(WriteReg), 32'd7);
        chk("starve_forced_data", WriteData, 32'h77);
        chk("starve_err_drop", 32'(err_drop), 32'(1'b1));

        // Bypass: registered write rd=4/0x10 against rs1=4 and rs1=0.
        set_idle();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h10;
        tick();
        alu_valid = 1'b0;
        rs1 = 5'd4; rf_data1 = 32'h99;
        #1;
`ifdef WB_BYPASS_EN
        chk("bypass_hit", fwd_data1, 32'h10);
`else
        chk("bypass_off", fwd_data1, 32'h99);
`endif
        rs1 = 5'd0;
        #1;
        chk("bypass_r0", fwd_data1, 32'h99);
        tick();

        // Fill the queue under constant ALU traffic: full queue refuses pushes.
        set_idle();
        rst_n = 1'b0;
        tick();
        chk("err_cleared", 32'(err_drop), 32'(1'b0));
        rst_n = 1'b1;
        low = 0;
        for (int i = 0; i < 14; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'(i);
            ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_data = 32'(16'hA000 + i);
            tick();
            if (!cur_ready) low++;
        end
        chk("full_ready_low_seen", 32'(low != 0), 32'(1'b1));

        // Reset with 3 queued entries: nothing stale retires afterward.
        set_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h5;
            ld_valid = 1'b1; ld_rd = 5'(20 + i); ld_data = 32'(i);
            tick();
        end
        set_idle();
        rst_n = 1'b0; ld_valid = 1'b1; ld_rd = 5'd25;
        tick();
        chk("mid_rst_ready_low", 32'(cur_ready), 32'(1'b0));
        chk("mid_rst_stall_low", 32'(cur_stall), 32'(1'b0));
        chk("mid_rst_RegWrite", 32'(RegWrite), 32'(1'b0));
        chk("mid_rst_WriteReg", 32'(WriteReg), 32'd0);
        set_idle();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_ready", 32'(cur_ready), 32'(1'b1));
            chk("post_rst_no_write", 32'(RegWrite), 32'(1'b0));
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            alu_valid = (m_starve == SMAX && mq.size() > 0) ? ($urandom_range(0, 19) == 0)
                                                            : ($urandom_range(0, 1) == 1);
            alu_rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            alu_data  = $urandom;
            ld_valid  = ($urandom_range(0, 2) != 0);
            ld_rd     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            ld_data   = $urandom;
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 7));
            rf_data1  = $urandom;
            rf_data2  = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
